// File: rtl/mem_responder_if.sv
// Accelerator memory interface: request, write-beat and read-beat channels.
// The master modport is the accelerator side; the slave modport is the memory side.
interface mem_responder_if #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64
) ();
    logic                     mem_req_valid;
    logic                     mem_req_opcode;
    logic [MEM_LEN_BITS-1:0]  mem_req_len;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic                     mem_wr_valid;
    logic [MEM_DATA_BITS-1:0] mem_wr_bits;
    logic                     mem_rd_valid;
    logic [MEM_DATA_BITS-1:0] mem_rd_bits;
    logic                     mem_rd_ready;

    modport master (
        output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        output mem_wr_valid, mem_wr_bits, mem_rd_ready,
        input  mem_rd_valid, mem_rd_bits
    );

    modport slave (
        input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
        output mem_rd_valid, mem_rd_bits
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves accelerator read/write bursts from an internal
// word-addressed RAM, with fixed read latency and a sticky dropped-request flag.
module mem_responder #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_BITS    = 10,
    parameter int RD_LATENCY    = 2
) (
    input  logic             clock,
    input  logic             reset,
    mem_responder_if.slave   mem,
    output logic             busy,
    output logic             req_drop
);
    localparam int OFF_BITS  = $clog2(MEM_DATA_BITS / 8);
    localparam int WAIT_BITS = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    logic [MEM_DATA_BITS-1:0] ram [2**DEPTH_BITS];

    state_t                   state_q, state_d;
    logic [DEPTH_BITS-1:0]    idx_q, idx_d;
    logic [MEM_LEN_BITS-1:0]  cnt_q, cnt_d;
    logic [WAIT_BITS-1:0]     wait_q, wait_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [MEM_DATA_BITS-1:0] rd_bits_q, rd_bits_d;
    logic                     busy_q, busy_d;
    logic                     req_drop_q, req_drop_d;

    logic [MEM_ADDR_BITS-1:0] word_addr_s;
    logic [DEPTH_BITS-1:0]    idx_next_s;
    logic                     wr_fire_s;

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        rd_valid_d = rd_valid_q;
        rd_bits_d  = rd_bits_q;

        word_addr_s = mem.mem_req_addr >> OFF_BITS;
        idx_next_s  = idx_q + DEPTH_BITS'(1);
        wr_fire_s   = (state_q == WR_DATA) && mem.mem_wr_valid;

        case (state_q)
            IDLE: begin
                if (mem.mem_req_valid) begin
                    idx_d = word_addr_s[DEPTH_BITS-1:0];
                    cnt_d = mem.mem_req_len;
                    if (mem.mem_req_opcode) begin
                        state_d = WR_DATA;
                    end else if (RD_LATENCY > 0) begin
                        state_d = RD_WAIT;
                        wait_d  = WAIT_BITS'(RD_LATENCY - 1);
                    end else begin
                        state_d    = RD_DATA;
                        rd_valid_d = 1'b1;
                        rd_bits_d  = ram[word_addr_s[DEPTH_BITS-1:0]];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (wait_q == WAIT_BITS'(0)) begin
                    state_d    = RD_DATA;
                    rd_valid_d = 1'b1;
                    rd_bits_d  = ram[idx_q];
                end else begin
                    wait_d = wait_q - WAIT_BITS'(1);
                end
            end
            RD_DATA: begin
                // The next beat is fetched on the transfer edge so there are no bubbles.
                if (rd_valid_q && mem.mem_rd_ready) begin
                    if (cnt_q == MEM_LEN_BITS'(0)) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                    end else begin
                        idx_d     = idx_next_s;
                        cnt_d     = cnt_q - MEM_LEN_BITS'(1);
                        rd_bits_d = ram[idx_next_s];
                    end
                end else begin
                    rd_valid_d = rd_valid_q;
                end
            end
            WR_DATA: begin
                if (mem.mem_wr_valid) begin
                    if (cnt_q == MEM_LEN_BITS'(0)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_next_s;
                        cnt_d = cnt_q - MEM_LEN_BITS'(1);
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
            end
        endcase

        busy_d     = (state_d != IDLE);
        req_drop_d = req_drop_q | (mem.mem_req_valid && (state_q != IDLE));
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_bits_q  <= '0;
            busy_q     <= 1'b0;
            req_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            rd_valid_q <= rd_valid_d;
            rd_bits_q  <= rd_bits_d;
            busy_q     <= busy_d;
            req_drop_q <= req_drop_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && wr_fire_s) begin
            ram[idx_q] <= mem.mem_wr_bits;
        end
    end

    assign mem.mem_rd_valid = rd_valid_q;
    assign mem.mem_rd_bits  = rd_bits_q;
    assign busy             = busy_q;
    assign req_drop         = req_drop_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: bursts, latency, backpressure,
// wrap, dropped requests, reset mid-burst and single-beat writes with gaps.
module tb_mem_responder;
    logic clock = 1'b0;
    logic reset;
    logic busy;
    logic req_drop;

    always #5 clock = ~clock;

    mem_responder_if #(.MEM_LEN_BITS(8), .MEM_ADDR_BITS(32), .MEM_DATA_BITS(64)) mif ();

    mem_responder #(
        .MEM_LEN_BITS(8), .MEM_ADDR_BITS(32), .MEM_DATA_BITS(64),
        .DEPTH_BITS(10), .RD_LATENCY(2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .mem     (mif.slave),
        .busy    (busy),
        .req_drop(req_drop)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] got_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic op, input logic [31:0] addr, input logic [7:0] len);
        mif.mem_req_valid  = 1'b1;
        mif.mem_req_opcode = op;
        mif.mem_req_len    = len;
        mif.mem_req_addr   = addr;
        step();
        mif.mem_req_valid  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [63:0] d [4], input int gap);
        issue(1'b1, addr, len);
        repeat (gap) step();
        if (gap > 0) check_val("wr_gap_busy", 64'(busy), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            mif.mem_wr_valid = 1'b1;
            mif.mem_wr_bits  = d[i];
            step();
        end
        mif.mem_wr_valid = 1'b0;
        check_val("wr_done_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input bit bp, input bit drop, output int first_cyc);
        logic [3:0]  pat = 4'b1001;
        logic [63:0] held_bits = 64'd0;
        bit          held = 1'b0;
        bit          done = 1'b0;
        bit          rdy;
        int          k = 0;
        got_q.delete();
        first_cyc = -1;
        issue(1'b0, addr, len);
        for (int c = 1; c <= 64 && !done; c++) begin
            if (!busy && !mif.mem_rd_valid) begin
                done = 1'b1;
            end else begin
                rdy = bp ? pat[k % 4] : 1'b1;
                if (drop && c == 4) begin
                    mif.mem_req_valid  = 1'b1;
                    mif.mem_req_opcode = 1'b1;
                    mif.mem_req_len    = 8'd0;
                    mif.mem_req_addr   = 32'd0;
                end else begin
                    mif.mem_req_valid = 1'b0;
                end
                if (mif.mem_rd_valid) begin
                    if (first_cyc < 0) first_cyc = c;
                    if (held) check_val("rd_hold", mif.mem_rd_bits, held_bits);
                    if (rdy) got_q.push_back(mif.mem_rd_bits);
                    held      = !rdy;
                    held_bits = mif.mem_rd_bits;
                    k++;
                end
                mif.mem_rd_ready = rdy;
                step();
            end
        end
        mif.mem_req_valid = 1'b0;
        mif.mem_rd_ready  = 1'b0;
        check_val("rd_done", 64'(done), 64'd1);
    endtask

    task automatic expect_beats(input string tag, input logic [63:0] exp [4], input int n);
        check_val({tag, "_count"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) check_val(tag, got_q[i], exp[i]);
        end
    endtask

    initial begin
        logic [63:0] d  [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
        logic [63:0] dw [4] = '{64'hAAAA_0001, 64'hBBBB_0002, 64'd0, 64'd0};
        logic [63:0] e  [4];
        int fc;

        mif.mem_req_valid  = 1'b0;
        mif.mem_req_opcode = 1'b0;
        mif.mem_req_len    = 8'd0;
        mif.mem_req_addr   = 32'd0;
        mif.mem_wr_valid   = 1'b0;
        mif.mem_wr_bits    = 64'd0;
        mif.mem_rd_ready   = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        check_val("rst_rd_valid", 64'(mif.mem_rd_valid), 64'd0);
        check_val("rst_rd_bits", mif.mem_rd_bits, 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_req_drop", 64'(req_drop), 64'd0);
        reset = 1'b0;
        step();

        // write then read back with ready held high
        do_write(32'h40, 8'd3, d, 0);
        do_read(32'h40, 8'd3, 1'b0, 1'b0, fc);
        check_val("rd_latency", 64'(fc), 64'd3);
        expect_beats("rd_basic", d, 4);
        check_val("rd_basic_no_drop", 64'(req_drop), 64'd0);

        // backpressure 1,0,0,1,...
        do_read(32'h40, 8'd3, 1'b1, 1'b0, fc);
        check_val("bp_latency", 64'(fc), 64'd3);
        expect_beats("rd_bp", d, 4);

        // index wrap from word 1023 to word 0
        do_write(32'h1FF8, 8'd1, dw, 0);
        do_read(32'h1FF8, 8'd1, 1'b0, 1'b0, fc);
        expect_beats("wrap_hi", dw, 2);
        e = '{dw[1], 64'd0, 64'd0, 64'd0};
        do_read(32'h0, 8'd0, 1'b0, 1'b0, fc);
        expect_beats("wrap_lo", e, 1);

        // request during a read burst is dropped
        do_read(32'h40, 8'd3, 1'b0, 1'b1, fc);
        expect_beats("drop_burst", d, 4);
        check_val("drop_flag", 64'(req_drop), 64'd1);
        step();
        check_val("drop_no_extra", 64'(mif.mem_rd_valid), 64'd0);
        check_val("drop_sticky", 64'(req_drop), 64'd1);
        check_val("drop_idle", 64'(busy), 64'd0);
        do_read(32'h0, 8'd0, 1'b0, 1'b0, fc);
        expect_beats("drop_no_write", e, 1);

        // reset on the second read beat
        issue(1'b0, 32'h40, 8'd3);
        mif.mem_rd_ready = 1'b1;
        step();
        step();
        check_val("mid_beat0", mif.mem_rd_bits, 64'h11);
        step();
        check_val("mid_beat1", mif.mem_rd_bits, 64'h22);
        reset = 1'b1;
        step();
        check_val("mid_rst_valid", 64'(mif.mem_rd_valid), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_drop", 64'(req_drop), 64'd0);
        reset = 1'b0;
        mif.mem_rd_ready = 1'b0;
        do_read(32'h40, 8'd3, 1'b0, 1'b0, fc);
        expect_beats("post_rst", d, 4);

        // single beat with delayed wr_valid; wr_valid in IDLE is ignored
        e = '{64'h5A5A_1234, 64'd0, 64'd0, 64'd0};
        do_write(32'h80, 8'd0, e, 5);
        mif.mem_wr_valid = 1'b1;
        mif.mem_wr_bits  = 64'hDEAD_BEEF;
        step();
        mif.mem_wr_valid = 1'b0;
        check_val("idle_wr_busy", 64'(busy), 64'd0);
        do_read(32'h80, 8'd0, 1'b0, 1'b0, fc);
        expect_beats("single", e, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
